// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the PC, IF/ID and ID/EX registers.
// It turns a load-use stall, an EX-stage redirect and a debug halt/step request into
// per-cycle enable and flush strobes. It also keeps saturating stall and flush counters.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   stall           load-use hazard: the ID instruction must hold
//   redirect        EX resolved a taken branch/jump; the PC loads the target
//   halt_req        level request from debug to halt the core
//   step_req        level request, sampled only while halted, to release one instruction
//   clr_cnt         synchronous clear of both performance counters
//   pc_en           PC register load enable
//   ifid_en         IF/ID register load enable
//   ifid_flush      IF/ID loads a NOP bubble
//   idex_flush      ID/EX loads a bubble
//   halted          registered; the core is drained and frozen
//   step_done       registered one-cycle pulse on return to halted after a step
//   stall_cnt       saturating count of load-use bubble cycles
//   flush_cnt       saturating count of accepted redirects
module pipe_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect,
  input  logic             halt_req,
  input  logic             step_req,
  input  logic             clr_cnt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halted,
  output logic             step_done,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned DrainW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DrainW-1:0] DrainInit = DrainW'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic [1:0] {StRun, StDrain, StHalted, StStep} state_e;

  state_e              state_q, state_d;
  logic [DrainW-1:0]   drain_cnt_q, drain_cnt_d;
  logic                halted_q, halted_d;
  logic                step_flag_q, step_flag_d;
  logic                step_done_q, step_done_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;

  logic pc_en_c, ifid_en_c, ifid_flush_c, idex_flush_c;
  logic stall_inc, flush_inc;

  always_comb begin
    state_d      = state_q;
    drain_cnt_d  = drain_cnt_q;
    halted_d     = halted_q;
    step_flag_d  = step_flag_q;
    step_done_d  = 1'b0;
    pc_en_c      = 1'b0;
    ifid_en_c    = 1'b0;
    ifid_flush_c = 1'b0;
    idex_flush_c = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;

    case (state_q)
      StRun, StDrain: begin
        // A redirect wins over a stall, because the stalled instruction is wrong-path.
        if (redirect) begin
          pc_en_c      = 1'b1;
          ifid_en_c    = 1'b1;
          ifid_flush_c = 1'b1;
          idex_flush_c = 1'b1;
          flush_inc    = 1'b1;
        end else if (stall) begin
          idex_flush_c = 1'b1;
          stall_inc    = 1'b1;
        end else if (state_q == StRun) begin
          pc_en_c   = 1'b1;
          ifid_en_c = 1'b1;
        end else begin
          // Drain: the ID instruction moves on and a bubble enters ID behind it.
          ifid_en_c    = 1'b1;
          ifid_flush_c = 1'b1;
        end

        if (state_q == StRun) begin
          // A halt request waits until no hazard is present.
          if (halt_req && !redirect && !stall) begin
            state_d     = StDrain;
            drain_cnt_d = DrainInit;
          end
        end else if (!halt_req) begin
          state_d     = StRun;
          step_flag_d = 1'b0;
        end else if (redirect) begin
          drain_cnt_d = DrainInit;
        end else if (!stall) begin
          if (drain_cnt_q == '0) begin
            state_d     = StHalted;
            halted_d    = 1'b1;
            step_done_d = step_flag_q;
            step_flag_d = 1'b0;
          end else begin
            drain_cnt_d = drain_cnt_q - DrainW'(1);
          end
        end
      end

      StHalted: begin
        idex_flush_c = 1'b1;
        if (!halt_req) begin
          state_d  = StRun;
          halted_d = 1'b0;
        end else if (step_req) begin
          state_d  = StStep;
          halted_d = 1'b0;
        end
      end

      StStep: begin
        pc_en_c     = 1'b1;
        ifid_en_c   = 1'b1;
        state_d     = StDrain;
        drain_cnt_d = DrainInit;
        step_flag_d = 1'b1;
      end

      default: state_d = StRun;
    endcase
  end

  // The clear takes priority over an increment. Both counters stick at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (clr_cnt) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall_inc && (stall_cnt_q != CntMax)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (flush_inc && (flush_cnt_q != CntMax)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StRun;
      drain_cnt_q <= DrainInit;
      halted_q    <= 1'b0;
      step_flag_q <= 1'b0;
      step_done_q <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      halted_q    <= halted_d;
      step_flag_q <= step_flag_d;
      step_done_q <= step_done_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // While reset is held, freeze the PC and IF/ID and fill the pipe with bubbles.
  assign pc_en      = ~rst & pc_en_c;
  assign ifid_en    = ~rst & ifid_en_c;
  assign ifid_flush = rst | ifid_flush_c;
  assign idex_flush = rst | idex_flush_c;
  assign halted     = halted_q;
  assign step_done  = step_done_q;
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  localparam int unsigned DRAIN = 3;
  localparam int unsigned CW    = 4;
  localparam int          CMAX  = (1 << CW) - 1;

  localparam int M_RUN    = 0;
  localparam int M_DRAIN  = 1;
  localparam int M_HALTED = 2;
  localparam int M_STEP   = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          stall = 1'b0, redirect = 1'b0, halt_req = 1'b0, step_req = 1'b0;
  logic          clr_cnt = 1'b0;
  logic          pc_en, ifid_en, ifid_flush, idex_flush, halted, step_done;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: the pipe mode, the bubbles still owed before halting, and the counters.
  int   m_mode;
  int   m_left;
  logic m_stepping;
  logic m_halted;
  logic m_done;
  int   m_stall;
  int   m_flush;

  pipe_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .redirect   (redirect),
    .halt_req   (halt_req),
    .step_req   (step_req),
    .clr_cnt    (clr_cnt),
    .pc_en      (pc_en),
    .ifid_en    (ifid_en),
    .ifid_flush (ifid_flush),
    .idex_flush (idex_flush),
    .halted     (halted),
    .step_done  (step_done),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v < CMAX) ? v + 1 : v;
  endfunction

  task automatic m_reset();
    m_mode     = M_RUN;
    m_left     = 0;
    m_stepping = 1'b0;
    m_halted   = 1'b0;
    m_done     = 1'b0;
    m_stall    = 0;
    m_flush    = 0;
  endtask

  task automatic check_regs(input string pfx);
    chk1({pfx, "_halted"}, halted, m_halted);
    chk1({pfx, "_step_done"}, step_done, m_done);
    chkn({pfx, "_stall_cnt"}, stall_cnt, CW'(m_stall));
    chkn({pfx, "_flush_cnt"}, flush_cnt, CW'(m_flush));
  endtask

  // Apply inputs, then compare the strobes and registered outputs against the model mid-cycle.
  task automatic drive(input logic st, input logic rd, input logic hr, input logic sr,
                       input logic cc);
    logic e_pc, e_ifid, e_iff, e_idf;
    stall = st; redirect = rd; halt_req = hr; step_req = sr; clr_cnt = cc;
    @(negedge clk);
    if (m_mode == M_RUN || m_mode == M_DRAIN) begin
      if (rd)                  {e_pc, e_ifid, e_iff, e_idf} = 4'b1111;
      else if (st)             {e_pc, e_ifid, e_iff, e_idf} = 4'b0001;
      else if (m_mode == M_RUN) {e_pc, e_ifid, e_iff, e_idf} = 4'b1100;
      else                     {e_pc, e_ifid, e_iff, e_idf} = 4'b0110;
    end else if (m_mode == M_HALTED) begin
      {e_pc, e_ifid, e_iff, e_idf} = 4'b0001;
    end else begin
      {e_pc, e_ifid, e_iff, e_idf} = 4'b1100;
    end
    chk1("pc_en", pc_en, e_pc);
    chk1("ifid_en", ifid_en, e_ifid);
    chk1("ifid_flush", ifid_flush, e_iff);
    chk1("idex_flush", idex_flush, e_idf);
    chk1("pc_en_without_ifid_en", pc_en & ~ifid_en, 1'b0);
    check_regs("reg");
  endtask

  // Clock edge, then advance the model with the inputs that were sampled at that edge.
  task automatic tick();
    @(posedge clk);
    m_done = 1'b0;
    case (m_mode)
      M_RUN, M_DRAIN: begin
        if (redirect)   m_flush = sat_inc(m_flush);
        else if (stall) m_stall = sat_inc(m_stall);
        if (m_mode == M_RUN) begin
          if (halt_req && !redirect && !stall) begin
            m_mode = M_DRAIN;
            m_left = DRAIN;
          end
        end else if (!halt_req) begin
          m_mode     = M_RUN;
          m_stepping = 1'b0;
        end else if (redirect) begin
          m_left = DRAIN;
        end else if (!stall) begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            m_mode     = M_HALTED;
            m_halted   = 1'b1;
            m_done     = m_stepping;
            m_stepping = 1'b0;
          end
        end
      end
      M_HALTED: begin
        if (!halt_req) begin
          m_mode   = M_RUN;
          m_halted = 1'b0;
        end else if (step_req) begin
          m_mode   = M_STEP;
          m_halted = 1'b0;
        end
      end
      default: begin
        m_mode     = M_DRAIN;
        m_left     = DRAIN;
        m_stepping = 1'b1;
      end
    endcase
    if (clr_cnt) begin
      m_stall = 0;
      m_flush = 0;
    end
    #1;
  endtask

  task automatic cyc(input logic st, input logic rd, input logic hr, input logic sr,
                     input logic cc);
    drive(st, rd, hr, sr, cc);
    tick();
  endtask

  // Assert reset away from a clock edge, check the reset outputs, and release after one edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    m_reset();
    chk1("rst_pc_en", pc_en, 1'b0);
    chk1("rst_ifid_en", ifid_en, 1'b0);
    chk1("rst_ifid_flush", ifid_flush, 1'b1);
    chk1("rst_idex_flush", idex_flush, 1'b1);
    check_regs("rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic hr;
    #2;
    do_reset();

    // Free run with no events.
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chkn("t1_stall_cnt", stall_cnt, '0);
    chkn("t1_flush_cnt", flush_cnt, '0);

    // A stall, then a redirect that arrives while the stall is still high.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk1("t2_c1_pc_en", pc_en, 1'b0);
    chk1("t2_c1_idex_flush", idex_flush, 1'b1);
    tick();
    chkn("t2_c1_stall_cnt", stall_cnt, CW'(1));
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk1("t2_c2_pc_en", pc_en, 1'b1);
    chk1("t2_c2_ifid_flush", ifid_flush, 1'b1);
    chk1("t2_c2_idex_flush", idex_flush, 1'b1);
    tick();
    chkn("t2_c2_stall_cnt", stall_cnt, CW'(1));
    chkn("t2_c2_flush_cnt", flush_cnt, CW'(1));

    // Halt: three drain cycles, then halted. Dropping the request resumes the run.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk1("t3_drain_pc_en", pc_en, 1'b0);
      chk1("t3_drain_ifid_flush", ifid_flush, 1'b1);
      chk1("t3_drain_halted", halted, 1'b0);
      tick();
    end
    chk1("t3_halted", halted, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk1("t3_resume_pc_en", pc_en, 1'b1);
    tick();

    // Single step from halted.
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk1("t4_halted", halted, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk1("t4_step_pc_en", pc_en, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk1("t4_drain_pc_en", pc_en, 1'b0);
      chk1("t4_drain_step_done", step_done, 1'b0);
      tick();
    end
    chk1("t4_step_done", step_done, 1'b1);
    chk1("t4_halted_after_step", halted, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk1("t4_step_done_pulse", step_done, 1'b0);

    // A redirect in the second drain cycle restarts the drain.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chkn("t5_flush_before", flush_cnt, CW'(1));
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chkn("t5_flush_after", flush_cnt, CW'(2));
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk1("t5_not_yet_halted", halted, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk1("t5_halted", halted, 1'b1);

    // Counter saturation, clear priority, and a reset in the middle of a drain.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chkn("t6_cleared", stall_cnt, '0);
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chkn("t6_saturated", stall_cnt, CW'(15));
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chkn("t6_clr_over_inc", stall_cnt, '0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk1("t6_run_after_reset", pc_en, 1'b1);
    tick();

    // Random traffic against the model; the halt request is sticky so drains can complete.
    hr = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 9) == 0) hr = ~hr;
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        cyc(($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 15), hr,
            ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 4));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
